dense_bias_loader: RTL and testbench
====================================

// Module: dense_bias_loader
// PURPOSE
//   Assembles the serial byte stream of dense-layer biases (from the UART/weight
//   loader path) into 32-bit little-endian words. Drives the write port of the
//   dense-bias RAM (10 x 32-bit = 40 bytes). Signals completion or a stalled
//   stream (timeout) to the top-level load sequencer.
// PARAMETERS
//   NUM_BIASES      10      words to load; last word written to address NUM_BIASES-1
//   ADDR_W          4       width of wr_addr; must satisfy 2**ADDR_W >= NUM_BIASES
//   TIMEOUT_CYCLES  1000000 idle clocks tolerated between bytes while loading
// PORTS
//   clk         in   1       system clock, all logic on rising edge
//   rst_n       in   1       asynchronous, active-low reset
//   load_start  in   1       1-cycle pulse: begin a new 40-byte load
//   byte_valid  in   1       byte_data is valid this cycle (1-cycle strobe, no backpressure)
//   byte_data   in   8       incoming byte
//   wr_addr     out  ADDR_W  bias RAM write address
//   wr_data     out  32      bias RAM write data
//   wr_en       out  1       bias RAM write strobe, exactly 1 cycle per word
//   busy        out  1       high while in LOAD
//   done        out  1       1-cycle pulse after the last word is written
//   timeout_err out  1       1-cycle pulse when the load is aborted on timeout
// BEHAVIOUR
//   Reset: all outputs 0; state=IDLE; byte_cnt=0; word_cnt=0; timer=0.
//   FSM states:
//     IDLE -> LOAD on load_start. Clears byte_cnt, word_cnt, timer.
//     LOAD -> FIN after the write of word NUM_BIASES-1.
//     LOAD -> IDLE on timeout.
//     FIN  -> IDLE after 1 cycle; done=1 during FIN.
//   IDLE: byte_valid is ignored and no write occurs.
//   LOAD: each byte_valid stores byte_data into lane byte_cnt.
//     Lane mapping: byte 0 -> [7:0], byte 1 -> [15:8], byte 2 -> [23:16],
//     byte 3 -> [31:24] (little-endian).
//     byte_cnt increments 0..3 and wraps to 0.
//   Write timing: the edge that captures byte 3 also registers
//     wr_data = {b3,b2,b1,b0}, wr_addr = word_cnt, wr_en = 1.
//     wr_en is therefore high for exactly the next cycle; word_cnt then increments.
//   Latency: wr_en is asserted 1 cycle after the 4th byte's strobe.
//   Back-to-back bytes (byte_valid every cycle) are accepted without loss.
//     The assembly register is independent of wr_data.
//   wr_data and wr_addr hold their last values when wr_en = 0.
//   On the last word, wr_en and the transition to FIN happen on the same edge.
//     done pulses in the cycle after wr_en.
//     Bytes arriving in FIN or IDLE are dropped.
//   Timer: counts clocks in LOAD; cleared on every byte_valid.
//     At timer == TIMEOUT_CYCLES-1 without a byte: timeout_err = 1 for 1 cycle,
//     go to IDLE, and discard the partial word (no wr_en).
//   load_start in LOAD or FIN is ignored (no restart).
//   Simultaneous load_start and byte_valid in IDLE: start the load; that byte is dropped.
//   rst_n low mid-load: immediate return to reset values; a partial word is never written.
//   Counter widths: byte_cnt 2 bits; word_cnt ADDR_W bits; timer $clog2(TIMEOUT_CYCLES) bits.
// TESTING
//   1. Reset, load_start, then 40 bytes 0x00..0x27 back-to-back ->
//      10 wr_en pulses at addr 0..9; word0 = 0x03020100, word9 = 0x27262524;
//      done pulses 1 cycle after the 10th wr_en.
//   2. Same 40 bytes with 5 idle cycles between bytes -> identical writes;
//      busy stays high throughout; no timeout_err.
//   3. Bytes sent before load_start, and 3 extra bytes after done ->
//      no wr_en outside the load; exactly 10 writes.
//   4. TIMEOUT_CYCLES=16: load_start, 6 bytes, then silence -> word0 written;
//      timeout_err pulses 16 cycles after byte 6; no write of the partial word 1;
//      busy = 0 afterwards.
//   5. rst_n asserted after 22 bytes, then a full load -> first run makes
//      writes 0..4 only; second run writes addr 0..9 starting from word 0.
//   6. load_start pulsed again at byte 10 -> ignored; the load completes
//      normally with 10 writes and one done.

Source files
------------

// File: rtl/dense_bias_loader_if.sv
// rtl/dense_bias_loader_if.sv - byte stream in, bias RAM write port and status out
interface dense_bias_loader_if #(
  parameter int ADDR_W = 4
);
  logic              load_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              wr_en;
  logic              busy;
  logic              done;
  logic              timeout_err;

  modport master (
    output load_start, byte_valid, byte_data,
    input  wr_addr, wr_data, wr_en, busy, done, timeout_err
  );

  modport slave (
    input  load_start, byte_valid, byte_data,
    output wr_addr, wr_data, wr_en, busy, done, timeout_err
  );
endinterface

// File: rtl/dense_bias_loader.sv
// rtl/dense_bias_loader.sv - packs serial bias bytes into 32-bit little-endian RAM writes
module dense_bias_loader #(
  parameter int NUM_BIASES     = 10,
  parameter int ADDR_W         = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  dense_bias_loader_if.slave bus
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            r_state;
  logic [1:0]        r_byte_cnt;
  logic [ADDR_W-1:0] r_word_cnt;
  logic [TMR_W-1:0]  r_timer;
  logic [23:0]       r_asm;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_wr_en;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout_err;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= S_IDLE;
      r_byte_cnt    <= '0;
      r_word_cnt    <= '0;
      r_timer       <= '0;
      r_asm         <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_en       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_wr_en       <= 1'b0;
      r_done        <= 1'b0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.load_start) begin
            r_state    <= S_LOAD;
            r_busy     <= 1'b1;
            r_byte_cnt <= '0;
            r_word_cnt <= '0;
            r_timer    <= '0;
          end
        end
        S_LOAD: begin
          if (bus.byte_valid) begin
            r_timer    <= '0;
            r_byte_cnt <= r_byte_cnt + 2'd1;
            case (r_byte_cnt)
              2'd0: r_asm[7:0]   <= bus.byte_data;
              2'd1: r_asm[15:8]  <= bus.byte_data;
              2'd2: r_asm[23:16] <= bus.byte_data;
              default: begin
                // Top byte goes straight to the write register so the
                // assembly register is free for the next word immediately.
                r_wr_data  <= {bus.byte_data, r_asm};
                r_wr_addr  <= r_word_cnt;
                r_wr_en    <= 1'b1;
                r_word_cnt <= r_word_cnt + 1'b1;
                if (r_word_cnt == ADDR_W'(NUM_BIASES - 1)) begin
                  r_state <= S_FIN;
                  r_busy  <= 1'b0;
                end
              end
            endcase
          end else if (r_timer == TMR_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_IDLE;
            r_busy        <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_FIN: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.wr_en       = r_wr_en;
  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dense_bias_loader.sv
// tb/tb_dense_bias_loader.sv - directed self-checking bench for dense_bias_loader
module tb_dense_bias_loader;

  localparam int NB     = 10;
  localparam int AW     = 4;
  localparam int TMO    = 16;

  logic clk;
  logic rst_n;

  dense_bias_loader_if #(.ADDR_W(AW)) bus ();

  dense_bias_loader #(
    .NUM_BIASES    (NB),
    .ADDR_W        (AW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  int            wc[$];
  int            n_done      = 0;
  int            done_cyc    = 0;
  int            n_to        = 0;
  int            n_busy_drop = 0;
  bit            watch_busy  = 1'b0;

  always @(negedge clk) begin
    if (bus.wr_en) begin
      wa.push_back(bus.wr_addr);
      wd.push_back(bus.wr_data);
      wc.push_back(cyc);
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.timeout_err) n_to++;
    if (watch_busy && !bus.busy) n_busy_drop++;
  end

  function automatic logic [31:0] exp_word(input int i);
    logic [7:0] b0, b1, b2, b3;
    b0 = 8'(4 * i);
    b1 = 8'(4 * i + 1);
    b2 = 8'(4 * i + 2);
    b3 = 8'(4 * i + 3);
    return {b3, b2, b1, b0};
  endfunction

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wc.delete();
    n_done      = 0;
    n_to        = 0;
    n_busy_drop = 0;
  endtask

  task automatic pulse_start();
    bus.load_start = 1'b1;
    @(posedge clk);
    #1 bus.load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    @(posedge clk);
    #1 bus.byte_valid = 1'b0;
    repeat (gap) @(posedge clk);
    if (gap > 0) #1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %b want 0", bus.wr_en); end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_checks++;
    if (bus.done !== 1'b0 || bus.timeout_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_status got done=%b to=%b want 0 0", bus.done, bus.timeout_err);
    end
    n_checks++;
    if (bus.wr_addr !== '0 || bus.wr_data !== '0) begin
      n_fail++; $display("FAIL reset_wr_port got addr=%0h data=%h want 0 0", bus.wr_addr, bus.wr_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    int c4;
    clear_log();
    pulse_start();
    c4 = 0;
    for (int i = 0; i < 4 * NB; i++) begin
      send_byte(8'(i), 0);
      if (i == 3) c4 = cyc;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (wa.size() != NB) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", wa.size(), NB); end
    for (int i = 0; i < NB && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== AW'(i) || wd[i] !== exp_word(i)) begin
        n_fail++; $display("FAIL b2b_word%0d got addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, exp_word(i));
      end
    end
    n_checks++;
    if (wd.size() < 1 || wd[0] !== 32'h0302_0100) begin n_fail++; $display("FAIL b2b_word0 want 03020100"); end
    n_checks++;
    if (wd.size() < NB || wd[NB-1] !== 32'h2726_2524) begin n_fail++; $display("FAIL b2b_word9 want 27262524"); end
    n_checks++;
    if (wc.size() < 1 || wc[0] != c4) begin n_fail++; $display("FAIL b2b_latency got cyc=%0d want %0d", (wc.size() > 0) ? wc[0] : -1, c4); end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL b2b_done_count got %0d want 1", n_done); end
    n_checks++;
    if (wc.size() < NB || done_cyc != wc[NB-1] + 1) begin
      n_fail++; $display("FAIL b2b_done_timing got cyc=%0d want %0d", done_cyc, (wc.size() >= NB) ? wc[NB-1] + 1 : -1);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_after got %b want 0", bus.busy); end
  endtask

  task automatic test_gapped();
    clear_log();
    pulse_start();
    watch_busy = 1'b1;
    for (int i = 0; i < 4 * NB - 1; i++) send_byte(8'(i), 5);
    watch_busy = 1'b0;
    send_byte(8'(4 * NB - 1), 0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (wa.size() != NB) begin n_fail++; $display("FAIL gap_count got %0d want %0d", wa.size(), NB); end
    for (int i = 0; i < NB && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== AW'(i) || wd[i] !== exp_word(i)) begin
        n_fail++; $display("FAIL gap_word%0d got addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, exp_word(i));
      end
    end
    n_checks++;
    if (n_busy_drop != 0) begin n_fail++; $display("FAIL gap_busy got %0d low cycles want 0", n_busy_drop); end
    n_checks++;
    if (n_to != 0) begin n_fail++; $display("FAIL gap_timeout got %0d want 0", n_to); end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL gap_done got %0d want 1", n_done); end
  endtask

  task automatic test_outside_load();
    clear_log();
    send_byte(8'hA1, 0);
    send_byte(8'hA2, 1);
    send_byte(8'hA3, 0);
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'hEE;
    pulse_start();
    bus.byte_valid = 1'b0;
    for (int i = 0; i < 4 * NB; i++) send_byte(8'(i), 0);
    repeat (3) @(posedge clk);
    #1;
    send_byte(8'hB1, 0);
    send_byte(8'hB2, 0);
    send_byte(8'hB3, 0);
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (wa.size() != NB) begin n_fail++; $display("FAIL outside_count got %0d want %0d", wa.size(), NB); end
    n_checks++;
    if (wd.size() < 1 || wd[0] !== 32'h0302_0100) begin
      n_fail++; $display("FAIL outside_word0 got %h want 03020100", (wd.size() > 0) ? wd[0] : 32'hx);
    end
    n_checks++;
    if (wa.size() < NB || wa[NB-1] !== AW'(NB - 1) || wd[NB-1] !== 32'h2726_2524) begin
      n_fail++; $display("FAIL outside_word9 want addr=9 data=27262524");
    end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL outside_done got %0d want 1", n_done); end
  endtask

  task automatic test_timeout();
    int n_edge;
    clear_log();
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(8'(i), 0);
    n_edge = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.timeout_err) begin
        n_edge = n;
        break;
      end
    end
    n_checks++;
    if (n_edge != TMO) begin n_fail++; $display("FAIL timeout_latency got %0d edges want %0d (0 = never)", n_edge, TMO); end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (n_to != 1) begin n_fail++; $display("FAIL timeout_pulses got %0d want 1", n_to); end
    n_checks++;
    if (wa.size() != 1 || wd[0] !== 32'h0302_0100 || wa[0] !== '0) begin
      n_fail++; $display("FAIL timeout_writes got %0d writes want 1 (addr 0, 03020100)", wa.size());
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL timeout_busy got %b want 0", bus.busy); end
    n_checks++;
    if (n_done != 0) begin n_fail++; $display("FAIL timeout_done got %0d want 0", n_done); end
  endtask

  task automatic test_reset_midload();
    clear_log();
    pulse_start();
    for (int i = 0; i < 22; i++) send_byte(8'(i), 0);
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.wr_en !== 1'b0) begin
      n_fail++; $display("FAIL midrst_outputs got busy=%b wr_en=%b want 0 0", bus.busy, bus.wr_en);
    end
    n_checks++;
    if (wa.size() != 5 || wa[4] !== AW'(4)) begin n_fail++; $display("FAIL midrst_first_run got %0d writes want 5", wa.size()); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_log();
    pulse_start();
    for (int i = 0; i < 4 * NB; i++) send_byte(8'(i), 0);
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (wa.size() != NB) begin n_fail++; $display("FAIL midrst_second_count got %0d want %0d", wa.size(), NB); end
    for (int i = 0; i < NB && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== AW'(i) || wd[i] !== exp_word(i)) begin
        n_fail++; $display("FAIL midrst_word%0d got addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, exp_word(i));
      end
    end
  endtask

  task automatic test_restart_ignored();
    clear_log();
    pulse_start();
    for (int i = 0; i < 4 * NB; i++) begin
      if (i == 10) bus.load_start = 1'b1;
      send_byte(8'(i), 0);
      bus.load_start = 1'b0;
    end
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (wa.size() != NB) begin n_fail++; $display("FAIL restart_count got %0d want %0d", wa.size(), NB); end
    for (int i = 0; i < NB && i < wa.size(); i++) begin
      n_checks++;
      if (wa[i] !== AW'(i) || wd[i] !== exp_word(i)) begin
        n_fail++; $display("FAIL restart_word%0d got addr=%0d data=%h want addr=%0d data=%h", i, wa[i], wd[i], i, exp_word(i));
      end
    end
    n_checks++;
    if (n_done != 1) begin n_fail++; $display("FAIL restart_done got %0d want 1", n_done); end
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.load_start = 1'b0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    test_reset();
    test_back_to_back();
    test_gapped();
    test_outside_load();
    test_timeout();
    test_reset_midload();
    test_restart_ignored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
